snake_dir_input: RTL and testbench

- Consumes the periodic 1-cycle tick from the upstream prescaler.
- Debounces the four raw direction buttons, generates press pulses, and maintains the snake heading.
- The heading has two registers: pending (from user input) and committed (at each game step).
- Blocks 180° reversals. Sits between the board buttons and the snake game engine.

---
 rtl/snake_dir_input.sv | 96 +++++++++
 tb/tb_snake_dir_input.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_input.sv
// Debounces four direction buttons, emits press pulses and tracks the snake heading.
// Pending heading follows accepted presses; committed heading latches pending on each step.
module snake_dir_input #(
  parameter logic [15:0] DEBOUNCE_TICKS = 16'd200,
  parameter logic [1:0]  INIT_DIR       = 2'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] btn_raw,
  input  logic       step,
  output logic [3:0] btn_state,
  output logic [3:0] btn_press,
  output logic [1:0] dir_pending,
  output logic [1:0] dir,
  output logic       dir_changed
);

  localparam logic [15:0] LAST_CNT = DEBOUNCE_TICKS - 16'd1;

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0][15:0] cnt_q, cnt_d;
  logic [3:0]       state_q, state_d;
  logic [3:0]       press_q, press_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       dir_q, dir_d;
  logic             chg_q, chg_d;
  logic [1:0]       cand;
  logic [1:0]       ref_dir;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    press_d = '0;
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= LAST_CNT) begin
          state_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
          press_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Lowest set press bit wins; up/down and left/right differ only in bit 0.
  always_comb begin
    if (press_q[0])      cand = 2'd0;
    else if (press_q[1]) cand = 2'd1;
    else if (press_q[2]) cand = 2'd2;
    else                 cand = 2'd3;
  end

  always_comb begin
    ref_dir = step ? pend_q : dir_q;
    pend_d  = pend_q;
    if ((|press_q) && (cand != (ref_dir ^ 2'd1))) begin
      pend_d = cand;
    end
    dir_d = step ? pend_q : dir_q;
    chg_d = step && (pend_q != dir_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      state_q <= '0;
      press_q <= '0;
      pend_q  <= INIT_DIR;
      dir_q   <= INIT_DIR;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      chg_q   <= chg_d;
    end
  end

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign dir_pending = pend_q;
  assign dir         = dir_q;
  assign dir_changed = chg_q;

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed bench for snake_dir_input: DEBOUNCE_TICKS=4, tick every 5 clk, INIT_DIR=3.
module tb_snake_dir_input;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] btn_raw = '0;
  logic       step = 1'b0;
  logic [3:0] btn_state, btn_press;
  logic [1:0] dir_pending, dir;
  logic       dir_changed;

  int checks = 0;
  int errors = 0;
  int tick_ph = 0;
  logic last_tick = 1'b0;

  snake_dir_input #(.DEBOUNCE_TICKS(16'd4), .INIT_DIR(2'd3)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_raw(btn_raw), .step(step),
    .btn_state(btn_state), .btn_press(btn_press), .dir_pending(dir_pending),
    .dir(dir), .dir_changed(dir_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive step/tick, clock, then sample 1 time unit after the edge.
  task automatic cyc(input logic s);
    step = s;
    tick = (tick_ph == 0);
    last_tick = tick;
    tick_ph = (tick_ph == 4) ? 0 : tick_ph + 1;
    @(posedge clk);
    #1;
    step = 1'b0;
    tick = 1'b0;
  endtask

  task automatic settle_released(input string tag);
    logic seen;
    seen = 1'b0;
    btn_raw = '0;
    for (int k = 0; k < 45; k++) begin
      cyc(1'b0);
      if (btn_press != 0) seen = 1'b1;
    end
    chk({tag, "_no_release_press"}, {15'd0, seen}, 16'd0);
    chk({tag, "_released_state"}, {12'd0, btn_state}, 16'd0);
  endtask

  // Hold buttons until the debounced press appears, then run the selection cycle.
  task automatic press_btn(input string tag, input logic [3:0] m, input logic s);
    int n;
    int guard;
    btn_raw = m;
    cyc(1'b0);
    cyc(1'b0);
    n = 0;
    guard = 0;
    while (btn_press == 0 && guard < 100) begin
      cyc(1'b0);
      if (last_tick) n++;
      guard++;
    end
    chk({tag, "_ticks"}, n[15:0], 16'd4);
    chk({tag, "_press"}, {12'd0, btn_press}, {12'd0, m});
    chk({tag, "_state"}, {12'd0, btn_state}, {12'd0, m});
    cyc(s);
    chk({tag, "_press_once"}, {12'd0, btn_press}, 16'd0);
    settle_released(tag);
  endtask

  initial begin
    int n;
    // 1. reset state, and reset dominating tick/step/buttons
    rst_n = 1'b0;
    repeat (3) cyc(1'b0);
    chk("rst_dir", {14'd0, dir}, 16'd3);
    chk("rst_pend", {14'd0, dir_pending}, 16'd3);
    chk("rst_state", {12'd0, btn_state}, 16'd0);
    chk("rst_press", {12'd0, btn_press}, 16'd0);
    chk("rst_chg", {15'd0, dir_changed}, 16'd0);
    btn_raw = 4'hf;
    repeat (12) cyc(1'b1);
    chk("rst_hold_dir", {14'd0, dir}, 16'd3);
    chk("rst_hold_pend", {14'd0, dir_pending}, 16'd3);
    chk("rst_hold_state", {12'd0, btn_state}, 16'd0);
    chk("rst_hold_chg", {15'd0, dir_changed}, 16'd0);
    btn_raw = '0;
    cyc(1'b0);
    rst_n = 1'b1;

    // 2. up press, commit, change pulse only once
    press_btn("up", 4'b0001, 1'b0);
    chk("up_pend", {14'd0, dir_pending}, 16'd0);
    chk("up_dir_before_step", {14'd0, dir}, 16'd3);
    cyc(1'b1);
    chk("up_dir", {14'd0, dir}, 16'd0);
    chk("up_chg", {15'd0, dir_changed}, 16'd1);
    cyc(1'b0);
    chk("up_chg_drop", {15'd0, dir_changed}, 16'd0);
    cyc(1'b1);
    chk("step2_dir", {14'd0, dir}, 16'd0);
    chk("step2_chg", {15'd0, dir_changed}, 16'd0);

    // 3. three-tick glitch on left is filtered
    btn_raw = 4'b0100;
    cyc(1'b0);
    cyc(1'b0);
    n = 0;
    for (int k = 0; k < 40 && n < 3; k++) begin
      cyc(1'b0);
      if (last_tick) n++;
    end
    chk("glitch_ticks", n[15:0], 16'd3);
    settle_released("glitch");
    chk("glitch_pend", {14'd0, dir_pending}, 16'd0);

    // back to heading right
    press_btn("right", 4'b1000, 1'b0);
    chk("right_pend", {14'd0, dir_pending}, 16'd3);
    cyc(1'b1);
    chk("right_dir", {14'd0, dir}, 16'd3);
    chk("right_chg", {15'd0, dir_changed}, 16'd1);

    // 4. reversal rejected; later requests overwrite, each checked against dir
    press_btn("rev_left", 4'b0100, 1'b0);
    chk("rev_left_pend", {14'd0, dir_pending}, 16'd3);
    press_btn("req_up", 4'b0001, 1'b0);
    chk("req_up_pend", {14'd0, dir_pending}, 16'd0);
    press_btn("req_down", 4'b0010, 1'b0);
    chk("req_down_pend", {14'd0, dir_pending}, 16'd1);
    cyc(1'b1);
    chk("down_dir", {14'd0, dir}, 16'd1);
    chk("down_chg", {15'd0, dir_changed}, 16'd1);

    // 5. press on the step cycle is checked against old pending
    press_btn("r5", 4'b1000, 1'b0);
    cyc(1'b1);
    chk("r5_dir", {14'd0, dir}, 16'd3);
    press_btn("u5", 4'b0001, 1'b0);
    chk("u5_pend", {14'd0, dir_pending}, 16'd0);
    btn_raw = 4'b0010;
    press_btn("d5_step", 4'b0010, 1'b1);
    chk("d5_dir", {14'd0, dir}, 16'd0);
    chk("d5_pend", {14'd0, dir_pending}, 16'd0);
    press_btn("l5_step", 4'b0100, 1'b1);
    chk("l5_dir", {14'd0, dir}, 16'd0);
    chk("l5_pend", {14'd0, dir_pending}, 16'd2);

    // 6. all four at once, then reset in mid-debounce
    press_btn("r6", 4'b1000, 1'b0);
    cyc(1'b1);
    chk("r6_dir", {14'd0, dir}, 16'd3);
    press_btn("all", 4'b1111, 1'b0);
    chk("all_pend", {14'd0, dir_pending}, 16'd0);

    btn_raw = 4'b0100;
    cyc(1'b0);
    cyc(1'b0);
    n = 0;
    for (int k = 0; k < 40 && n < 3; k++) begin
      cyc(1'b0);
      if (last_tick) n++;
    end
    rst_n = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    chk("mid_rst_state", {12'd0, btn_state}, 16'd0);
    chk("mid_rst_pend", {14'd0, dir_pending}, 16'd3);
    chk("mid_rst_dir", {14'd0, dir}, 16'd3);
    rst_n = 1'b1;
    press_btn("post_rst", 4'b0100, 1'b0);
    chk("post_rst_pend", {14'd0, dir_pending}, 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
